// File: rtl/simddr_pkg.sv
// rtl/simddr_pkg.sv - shared FSM state type and geometry helper for the simulated DDR model
package simddr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int beat_idx_w(input int beats);
    return $clog2(beats);
  endfunction

endpackage

// File: rtl/simddr_lfsr.sv
// rtl/simddr_lfsr.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying latency jitter
// Only present when SIMDDR_RANDLAT_EN is defined.
`ifdef SIMDDR_RANDLAT_EN
module simddr_lfsr (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] o_jitter
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_jitter = r_lfsr[2:0];

endmodule
`endif

// File: rtl/simddr_burst.sv
// rtl/simddr_burst.sv - word-addressed simulated DDR, single masked or line-burst access
// Define SIMDDR_RANDLAT_EN to add 0..7 cycles of LFSR jitter to each access latency.
module simddr_burst
  import simddr_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 64,
  parameter int BURST_BEATS = 8,
  parameter int LATENCY     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ddr_chip_enable,
  input  logic [ADDR_W-1:0]             ddr_index,
  input  logic                          ddr_write_enable,
  input  logic                          ddr_burst_mode,
  input  logic [DATA_W-1:0]             ddr_write_mask,
  input  logic [DATA_W-1:0]             ddr_write_data,
  input  logic [DATA_W*BURST_BEATS-1:0] ddr_burst_write_data,
  output logic [DATA_W-1:0]             ddr_read_data,
  output logic [DATA_W*BURST_BEATS-1:0] ddr_burst_read_data,
  output logic                          ddr_operation_done,
  output logic                          ddr_ready
);

  localparam int BW     = beat_idx_w(BURST_BEATS);
  localparam int LINE_W = DATA_W * BURST_BEATS;
`ifdef SIMDDR_RANDLAT_EN
  localparam int LAT_MAX = LATENCY + 7;
`else
  localparam int LAT_MAX = LATENCY;
`endif
  localparam int CNT_W = $clog2(LAT_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] index;
    logic              we;
    logic              burst;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  state_t            r_state;
  req_t              r_req;
  logic [LINE_W-1:0] r_wline;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [BW-1:0]     r_beat;
  logic              r_done;
  logic [DATA_W-1:0] r_rdata;
  logic [LINE_W-1:0] r_rline;

  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_line_base;
  logic [ADDR_W-1:0] w_beat_addr;
  logic [CNT_W-1:0]  w_lat_load;

  assign w_ready     = (r_state == IDLE) || (r_state == DONE);
  assign w_accept    = w_ready && ddr_chip_enable;
  assign w_line_base = {ddr_index[ADDR_W-1:BW], {BW{1'b0}}};
  // Bases are line-aligned, so beat k's address is the base with k in the low bits.
  assign w_beat_addr = {r_req.index[ADDR_W-1:BW], r_beat};

`ifdef SIMDDR_RANDLAT_EN
  logic [2:0] w_jitter;

  simddr_lfsr u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .o_jitter (w_jitter)
  );

  assign w_lat_load = CNT_W'(LATENCY) + CNT_W'(w_jitter);
`else
  assign w_lat_load = CNT_W'(LATENCY);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_beat    <= '0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_rline   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_req.index <= ddr_burst_mode ? w_line_base : ddr_index;
            r_req.we    <= ddr_write_enable;
            r_req.burst <= ddr_burst_mode;
            r_req.mask  <= ddr_write_mask;
            r_req.wdata <= ddr_write_data;
            r_wline     <= ddr_burst_write_data;
            r_lat_cnt   <= w_lat_load;
            r_beat      <= '0;
            r_state     <= WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_lat_cnt == CNT_W'(1)) begin
            r_lat_cnt <= '0;
            if (r_req.burst) begin
              r_beat  <= '0;
              r_state <= XFER;
            end else begin
              if (r_req.we) begin
                r_mem[r_req.index] <= (r_mem[r_req.index] & ~r_req.mask) |
                                      (r_req.wdata & r_req.mask);
              end else begin
                r_rdata <= r_mem[r_req.index];
              end
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - CNT_W'(1);
          end
        end
        XFER: begin
          if (r_req.we) begin
            r_mem[w_beat_addr] <= r_wline[r_beat*DATA_W +: DATA_W];
          end else begin
            r_rline[r_beat*DATA_W +: DATA_W] <= r_mem[w_beat_addr];
          end
          r_beat <= r_beat + BW'(1);
          if (r_beat == BW'(BURST_BEATS - 1)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ddr_ready           = w_ready;
  assign ddr_operation_done  = r_done;
  assign ddr_read_data       = r_rdata;
  assign ddr_burst_read_data = r_rline;

endmodule

// File: tb/tb_simddr_burst.sv
// tb/tb_simddr_burst.sv - scoreboard bench for simddr_burst (LATENCY=4, 8 beats of 64 bits)
module tb_simddr_burst;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int LW = DW * NB;

  logic          clock = 1'b0;
  logic          reset;
  logic          ce;
  logic [AW-1:0] idx;
  logic          we;
  logic          burst;
  logic [DW-1:0] mask;
  logic [DW-1:0] wdata;
  logic [LW-1:0] wline;
  logic [DW-1:0] rdata;
  logic [LW-1:0] rline;
  logic          done;
  logic          ready;

  simddr_burst #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_BEATS(NB), .LATENCY(4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .ddr_chip_enable      (ce),
    .ddr_index            (idx),
    .ddr_write_enable     (we),
    .ddr_burst_mode       (burst),
    .ddr_write_mask       (mask),
    .ddr_write_data       (wdata),
    .ddr_burst_write_data (wline),
    .ddr_read_data        (rdata),
    .ddr_burst_read_data  (rline),
    .ddr_operation_done   (done),
    .ddr_ready            (ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            done_cyc;
    logic [DW-1:0] rd;
    logic [LW-1:0] line;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] last_rd = '0;
  logic [LW-1:0] last_line = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", LW'(cyc), LW'(e.done_cyc));
        chk("read_data", LW'(rdata), LW'(e.rd));
        chk("burst_read_data", rline, e.line);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout act=0 exp=1");
    end
  endtask

  // Present a request in the current cycle T; it is accepted at the edge ending T.
  task automatic issue(input logic w, input logic b, input logic [AW-1:0] i,
                       input logic [DW-1:0] m, input logic [DW-1:0] d,
                       input logic [LW-1:0] l, input logic hold);
    exp_t e;
    @(negedge clock);
    wait_ready();
    we = w; burst = b; idx = i; mask = m; wdata = d; wline = l; ce = 1'b1;
    e.done_cyc = cyc + (b ? 13 : 5);
    e.rd = last_rd;
    e.line = last_line;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (!hold) ce = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [LW-1:0] line;
    exp_t          e;
    reset = 1'b1; ce = 1'b0; idx = '0; we = 1'b0; burst = 1'b0;
    mask = '0; wdata = '0; wline = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_ready", LW'(ready), LW'(1));
    chk("reset_done", LW'(done), LW'(0));
    chk("reset_rdata", LW'(rdata), '0);
    chk("reset_rline", rline, '0);

    // Full-mask write, then read back.
    issue(1'b1, 1'b0, 8'h10, '1, 64'hFFFF_0000_1234_5678, '0, 1'b0);
    wait_done();
    last_rd = 64'hFFFF_0000_1234_5678;
    issue(1'b0, 1'b0, 8'h10, '0, '0, '0, 1'b0);
    wait_done();

    // Low-half masked write of zero.
    issue(1'b1, 1'b0, 8'h10, 64'h0000_0000_FFFF_FFFF, 64'h0, '0, 1'b0);
    wait_done();
    last_rd = 64'hFFFF_0000_0000_0000;
    issue(1'b0, 1'b0, 8'h10, '0, '0, '0, 1'b0);
    wait_done();

    // Burst write at unaligned index 0x23 lands on line 0x20, beat k = k+1.
    for (int k = 0; k < NB; k++) line[k*DW +: DW] = DW'(k + 1);
    issue(1'b1, 1'b1, 8'h23, '1, 64'hDEAD, line, 1'b0);
    wait_done();
    last_line = line;
    issue(1'b0, 1'b1, 8'h27, '0, '0, '0, 1'b0);
    wait_done();
    last_rd = 64'd6;
    issue(1'b0, 1'b0, 8'h25, '0, '0, '0, 1'b0);
    wait_done();

    // Strobes during WAIT are dropped: exactly one done for this read.
    last_rd = 64'hFFFF_0000_0000_0000;
    issue(1'b0, 1'b0, 8'h10, '0, '0, '0, 1'b0);
    @(negedge clock);
    idx = 8'h25; ce = 1'b1;
    @(negedge clock);
    ce = 1'b0;
    wait_done();
    repeat (10) @(negedge clock);

    // Request held through DONE is re-accepted with no IDLE gap: second done at T+10.
    last_rd = 64'd6;
    issue(1'b0, 1'b0, 8'h25, '0, '0, '0, 1'b1);
    e.done_cyc = exp_q[0].done_cyc + 5;
    e.rd = 64'd6;
    e.line = last_line;
    exp_q.push_back(e);
    repeat (5) @(posedge clock);
    #1 ce = 1'b0;
    wait_done();

    // Reset during beat 3 of a burst write keeps beats 0..2 only.
    for (int k = 0; k < NB; k++) line[k*DW +: DW] = DW'(64'h50 + k);
    issue(1'b1, 1'b1, 8'h40, '0, '0, line, 1'b0);
    wait_done();
    for (int k = 0; k < NB; k++) line[k*DW +: DW] = DW'(64'hA0 + k);
    issue(1'b1, 1'b1, 8'h40, '0, '0, line, 1'b0);
    void'(exp_q.pop_back());
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_rdata_cleared", LW'(rdata), '0);
    chk("abort_ready", LW'(ready), LW'(1));
    last_rd = '0;
    for (int k = 0; k < NB; k++) line[k*DW +: DW] = (k < 3) ? DW'(64'hA0 + k) : DW'(64'h50 + k);
    last_line = line;
    issue(1'b0, 1'b1, 8'h40, '0, '0, '0, 1'b0);
    wait_done();

    repeat (5) @(negedge clock);
    chk("queue_empty", LW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
